// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fullsub_cell.sv
// One-bit full subtractor: d = a - b - bin (mod 2), bo set when the
// subtraction had to borrow from the next bit position.
module fullsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  // Difference is the parity of the three inputs; a borrow is needed when
  // b exceeds a, or when a equals b and a borrow is already pending.
  always_comb begin
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fullsub_cell is reused for every operand bit,
// LSB first, one bit per clock. Operands are captured on an accepted start,
// the result is published (and held) when the last bit has been processed.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter must be able to hold WIDTH so the increment on the final bit
  // never wraps.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_next;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bo;

  fullsub_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (br),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // The bit being processed this cycle is the final one when the counter
  // has reached WIDTH-1; the partial result gains the new bit at its MSB.
  always_comb begin
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
    diff_next = (diff_sh >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are decoded straight from the state, so exactly one is high.
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
  end

  // Datapath: capture operands on accept, shift one bit per RUN cycle, and
  // publish the complete result only on the final bit so partial values are
  // never visible on diff/bout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            br      <= bin;
            cnt     <= '0;
            diff_sh <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          br      <= cell_bo;
          cnt     <= cnt + CNT_W'(1);
          diff_sh <= diff_next;
          if (last_bit) begin
            diff <= diff_next;
            bout <= cell_bo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit subtractor controller that time-shares one full-subtractor cell across all operand bits, LSB first, one bit per clock.
- Accepts operands with a start/ready handshake, sequences the cell for WIDTH cycles, then returns difference and final borrow with a one-cycle done pulse.
- Sits beside the combinational subtractor cells as the area-minimal alternative to a ripple array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  a - b - bin mod 2^WIDTH, held until next accepted start
- bout  output  1  final borrow out, held with diff

Behaviour:
- Reset (async, any state): state=IDLE; ready=1; busy=0; done=0; diff=0; bout=0; internal operand shift regs, borrow reg and counter = 0. Reset mid-RUN aborts; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge → load a_sh=a, b_sh=b, br=bin, cnt=0, diff_sh=0; go to RUN.
  - start=0 → stay in IDLE; diff/bout hold their last values.
- RUN, each edge:
  - Cell inputs: a_sh[0], b_sh[0], br.
  - d = a_sh[0]^b_sh[0]^br; borrow = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - diff_sh shifts right with d entering at MSB; a_sh and b_sh shift right; br=borrow; cnt++.
  - When cnt reaches WIDTH-1 (final bit processed on this edge) → DONE.
- DONE (exactly 1 cycle): done=1; diff=diff_sh; bout=br; next edge → IDLE.
- Latency: start accepted at edge E0; done high during the cycle after edge E0+WIDTH; next start is accepted no earlier than edge E0+WIDTH+2.
- start during RUN or DONE is ignored (not queued). a/b/bin changes after acceptance have no effect.
- WIDTH=1: one RUN cycle, then DONE.
- cnt width is $clog2(WIDTH+1) bits; no wrap is possible.
- ready, busy and done are registered/decoded from state; they are mutually exclusive, exactly one is high.
- diff/bout outputs update only on entry to DONE; they are never exposed mid-computation.

Decomposition:
- Shared package serial_sub_pkg: state enum (IDLE, RUN, DONE), DEFAULT_WIDTH constant.
- Sub-module fullsub_cell: purely combinational 1-bit full subtractor (a, b, bin → d, bo), instantiated once. Controller, shift registers and counter live in serial_sub_ctrl.

Test Plan:
- WIDTH=8: a=8'd5, b=8'd3, bin=0, start pulse → done exactly 9 cycles after the accept edge; diff=8'h02, bout=0.
- a=8'd3, b=8'd5, bin=0 → diff=8'hFE, bout=1. Then a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1.
- a=8'hFF, b=8'hFF, bin=0 → diff=8'h00, bout=0. Hold start high continuously → results back-to-back with period WIDTH+2; ready low throughout RUN/DONE.
- Start accepted with a=8'd10, b=8'd1. Assert start with a=8'd0, b=8'd1 at RUN cycle 3 → ignored; result diff=8'd9, bout=0; exactly one done pulse.
- Assert rst at RUN cycle 4 → immediately ready=1, busy=0, diff=0, bout=0; no done pulse. A subsequent run with a=8'd7, b=8'd2 → diff=8'd5.
- WIDTH=1, exhaustive over all 8 combinations of a, b, bin: results match the full-subtractor truth table; done is asserted 2 cycles after accept.
